// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional odd parity, stop bit(s).
// Bit timing is 16 ticks of the shared tick_16x strobe per bit; all outputs are registered.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 parity_enable,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;

  logic in_bit_state;
  logic bit_end;

  assign in_bit_state = (state_q == StStart) || (state_q == StData) ||
                        (state_q == StParity) || (state_q == StStop);
  assign bit_end      = in_bit_state && tick_16x && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;

    // The 15 -> 0 wrap on a bit end doubles as the clear on entry to the next state.
    if (in_bit_state && tick_16x) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (tx_valid) begin
          state_d   = StStart;
          shift_d   = tx_data;
          par_en_d  = parity_enable;
          par_bit_d = ~^tx_data;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = StDone;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      StDone: begin
        tick_cnt_d = '0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    tx_pin_d   = 1'b1;
    tx_ready_d = (state_d == StIdle);
    tx_busy_d  = (state_d == StStart) || (state_d == StData) ||
                 (state_d == StParity) || (state_d == StStop);
    tx_done_d  = (state_d == StDone);
    case (state_d)
      StStart:  tx_pin_d = 1'b0;
      StData:   tx_pin_d = shift_d[0];
      StParity: tx_pin_d = par_bit_d;
      default:  tx_pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_pin_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_pin_q   <= tx_pin_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_pin   = tx_pin_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an 8-bit/1-stop instance and a 7-bit/2-stop instance share
// clock, reset and tick; frames are sampled mid-bit and compared against hand-computed values.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_16x = 1'b0;
  logic       par_en = 1'b0;
  logic [7:0] data_a = '0;
  logic       valid_a = 1'b0;
  logic       ready_a, pin_a, busy_a, done_a;
  logic [6:0] data_b = '0;
  logic       valid_b = 1'b0;
  logic       ready_b, pin_b, busy_b, done_b;

  int checks = 0;
  int failures = 0;
  int ticks = 0;
  int tick_mode = 2;  // 0: no ticks, 1: held high, 2: one tick every third clk
  int div = 0;
  bit sel = 1'b0;     // 0 selects the 8-bit instance, 1 the 7-bit/2-stop instance

  logic cur_pin, cur_ready, cur_busy, cur_done;
  assign cur_pin   = sel ? pin_b   : pin_a;
  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_busy  = sel ? busy_b  : busy_a;
  assign cur_done  = sel ? done_b  : done_a;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .tick_16x      (tick_16x),
    .parity_enable (par_en),
    .tx_data       (data_a),
    .tx_valid      (valid_a),
    .tx_ready      (ready_a),
    .tx_pin        (pin_a),
    .tx_busy       (busy_a),
    .tx_done       (done_a)
  );

  uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .tick_16x      (tick_16x),
    .parity_enable (par_en),
    .tx_data       (data_b),
    .tx_valid      (valid_b),
    .tx_ready      (ready_b),
    .tx_pin        (pin_b),
    .tx_busy       (busy_b),
    .tx_done       (done_b)
  );

  always #5 clk = ~clk;

  // Tick changes 2 ns after an edge, so the value seen at #1 is the one the last edge used.
  always @(posedge clk) begin
    #2;
    if (tick_mode == 0) begin
      tick_16x = 1'b0;
    end else if (tick_mode == 1) begin
      tick_16x = 1'b1;
    end else begin
      div = (div == 2) ? 0 : div + 1;
      tick_16x = (div == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_16x) ticks++;
  endtask

  task automatic drive(input logic [8:0] data, input bit valid);
    if (sel) begin
      data_b  = data[6:0];
      valid_b = valid;
    end else begin
      data_a  = data[7:0];
      valid_a = valid;
    end
  endtask

  // Sends one frame on the selected instance. samp[k] is tx_pin sampled mid-way through
  // frame bit k; glitches counts cycles where pin/busy/ready disagree with the frame model.
  task automatic send_frame(input string tag, input logic [8:0] data, input bit par,
                            input bit keep_valid, input logic [8:0] next_data,
                            input bit pulse_mid, output logic [15:0] samp,
                            output int done_tick, output int glitches, output int lat);
    int          nd, ns, nbits, k;
    logic [15:0] expf;
    logic        p;
    bit          pulsed, pulse_on;
    nd = sel ? 7 : 8;
    ns = sel ? 2 : 1;
    expf = '1;
    expf[0] = 1'b0;
    p = 1'b1;
    for (int i = 0; i < nd; i++) begin
      expf[1+i] = data[i];
      p = p ^ data[i];
    end
    if (par) expf[1+nd] = p;
    nbits = 1 + nd + (par ? 1 : 0) + ns;
    samp = '1;
    done_tick = -1;
    glitches = 0;
    lat = 0;
    pulsed = 1'b0;
    pulse_on = 1'b0;
    while (!cur_ready && lat < 100) begin
      if (cur_pin !== 1'b1) glitches++;
      step();
      lat++;
    end
    if (!cur_ready) begin
      check({tag, "_ready_timeout"}, 32'(cur_ready), 32'd1);
      return;
    end
    if (cur_pin !== 1'b1) glitches++;
    drive(data, 1'b1);
    par_en = par;
    step();
    ticks = 0;
    check({tag, "_start"}, 32'({cur_busy, cur_ready, cur_pin}), 32'b100);
    drive(next_data, keep_valid);
    par_en = ~par;
    for (int c = 0; c < 16 * nbits * 4 + 64; c++) begin
      step();
      if (pulse_on) begin
        drive(next_data, 1'b0);
        pulse_on = 1'b0;
      end
      if (cur_done) begin
        done_tick = ticks;
        if (cur_pin !== 1'b1 || cur_busy !== 1'b0) glitches++;
        break;
      end
      k = ticks / 16;
      if (cur_pin !== ((k < nbits) ? expf[k] : 1'b1)) glitches++;
      if (cur_busy !== 1'b1 || cur_ready !== 1'b0) glitches++;
      if (ticks % 16 == 8 && k < 16) samp[k] = cur_pin;
      if (pulse_mid && !pulsed && ticks >= 40) begin
        pulsed = 1'b1;
        pulse_on = 1'b1;
        check({tag, "_busy_not_ready"}, 32'(cur_ready), 32'd0);
        drive(~data, 1'b1);
      end
    end
    if (done_tick < 0) check({tag, "_done_timeout"}, 32'(cur_done), 32'd1);
  endtask

  logic [15:0] s;
  int          dt, g, l, dones, guard;

  initial begin
    repeat (3) step();
    check("rst_a", 32'({pin_a, ready_a, busy_a, done_a}), 32'b1100);
    check("rst_b", 32'({pin_b, ready_b, busy_b, done_b}), 32'b1100);
    reset = 1'b0;
    step();

    send_frame("a5", 9'h0A5, 1'b0, 1'b0, 9'h0FF, 1'b0, s, dt, g, l);
    check("a5_bits", 32'(s[9:0]), 32'b1101001010);
    check("a5_done_tick", 32'(dt), 32'd160);
    check("a5_glitch", 32'(g), 32'd0);
    step();
    check("a5_after_done", 32'({done_a, ready_a, pin_a, busy_a}), 32'b0110);

    send_frame("p00", 9'h000, 1'b1, 1'b0, 9'h0AA, 1'b0, s, dt, g, l);
    check("p00_bits", 32'(s[10:0]), 32'b11000000000);
    check("p00_done_tick", 32'(dt), 32'd176);
    check("p00_glitch", 32'(g), 32'd0);

    send_frame("p07", 9'h007, 1'b1, 1'b0, 9'h000, 1'b1, s, dt, g, l);
    check("p07_bits", 32'(s[10:0]), 32'b10000001110);
    check("p07_done_tick", 32'(dt), 32'd176);
    check("p07_glitch", 32'(g), 32'd0);

    send_frame("b2b1", 9'h055, 1'b0, 1'b1, 9'h03C, 1'b0, s, dt, g, l);
    check("b2b1_bits", 32'(s[9:0]), 32'b1010101010);
    check("b2b1_done_tick", 32'(dt), 32'd160);
    check("b2b1_glitch", 32'(g), 32'd0);
    send_frame("b2b2", 9'h03C, 1'b0, 1'b0, 9'h000, 1'b0, s, dt, g, l);
    check("b2b2_gap", 32'(l), 32'd1);
    check("b2b2_bits", 32'(s[9:0]), 32'b1001111000);
    check("b2b2_done_tick", 32'(dt), 32'd160);
    check("b2b2_glitch", 32'(g), 32'd0);

    tick_mode = 1;
    step();
    send_frame("held", 9'h0C3, 1'b1, 1'b0, 9'h000, 1'b0, s, dt, g, l);
    check("held_bits", 32'(s[10:0]), 32'b11110000110);
    check("held_done_tick", 32'(dt), 32'd176);
    check("held_glitch", 32'(g), 32'd0);
    tick_mode = 2;

    // Reset in the middle of data bit 3 (frame ticks 64..79).
    repeat (2) step();
    dones = 0;
    data_a = 8'hF0;
    par_en = 1'b0;
    valid_a = 1'b1;
    step();
    ticks = 0;
    valid_a = 1'b0;
    guard = 0;
    while (ticks < 69 && guard < 1000) begin
      step();
      if (done_a) dones++;
      guard++;
    end
    check("rst_pre_pin", 32'({pin_a, busy_a}), 32'b01);
    reset = 1'b1;
    step();
    check("rst_mid", 32'({pin_a, ready_a, busy_a, done_a}), 32'b1100);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done_a) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
    check("rst_idle", 32'({pin_a, ready_a, busy_a}), 32'b110);

    sel = 1'b1;
    send_frame("b7", 9'h07F, 1'b0, 1'b0, 9'h000, 1'b0, s, dt, g, l);
    check("b7_bits", 32'(s[9:0]), 32'b1111111110);
    check("b7_data", 32'(s[7:1]), 32'h7F);
    check("b7_done_tick", 32'(dt), 32'd160);
    check("b7_glitch", 32'(g), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
